// File: rtl/md_pad_pkg.sv
// Shared definitions for the Mega Drive pad responder: joystick/pad bit
// positions, phase constants and the output-row encoder.
package md_pad_pkg;

  localparam int JB_R     = 0;
  localparam int JB_L     = 1;
  localparam int JB_D     = 2;
  localparam int JB_U     = 3;
  localparam int JB_B     = 4;
  localparam int JB_C     = 5;
  localparam int JB_A     = 6;
  localparam int JB_START = 7;
  localparam int JB_MODE  = 8;
  localparam int JB_X     = 9;
  localparam int JB_Y     = 10;
  localparam int JB_Z     = 11;

  localparam int PD_UP    = 0;
  localparam int PD_DOWN  = 1;
  localparam int PD_LEFT  = 2;
  localparam int PD_RIGHT = 3;
  localparam int PD_TL    = 4;
  localparam int PD_TR    = 5;

  localparam logic [2:0] PHASE_ID  = 3'd3;
  localparam logic [2:0] PHASE_MAX = 3'd4;

  localparam int TIMEOUT_CYCLES_DEFAULT = 60000;

  typedef enum logic [2:0] {
    ROW_DPAD,
    ROW_EXTRA,
    ROW_START,
    ROW_ID,
    ROW_ALLHI
  } pad_row_e;

  // Active-low encoding of one joystick word onto the six DB9 data lines.
  function automatic logic [5:0] pad_encode(input logic [11:0] joy, input pad_row_e row);
    logic [5:0] p;
    p = 6'h3F;
    case (row)
      ROW_DPAD: begin
        p[PD_TR]    = ~joy[JB_C];
        p[PD_TL]    = ~joy[JB_B];
        p[PD_RIGHT] = ~joy[JB_R];
        p[PD_LEFT]  = ~joy[JB_L];
        p[PD_DOWN]  = ~joy[JB_D];
        p[PD_UP]    = ~joy[JB_U];
      end
      ROW_EXTRA: begin
        p[PD_TR]    = ~joy[JB_C];
        p[PD_TL]    = ~joy[JB_B];
        p[PD_RIGHT] = ~joy[JB_MODE];
        p[PD_LEFT]  = ~joy[JB_X];
        p[PD_DOWN]  = ~joy[JB_Y];
        p[PD_UP]    = ~joy[JB_Z];
      end
      ROW_START: begin
        p[PD_TR]    = ~joy[JB_START];
        p[PD_TL]    = ~joy[JB_A];
        p[PD_RIGHT] = 1'b0;
        p[PD_LEFT]  = 1'b0;
        p[PD_DOWN]  = ~joy[JB_D];
        p[PD_UP]    = ~joy[JB_U];
      end
      ROW_ID: begin
        p[PD_TR]    = ~joy[JB_START];
        p[PD_TL]    = ~joy[JB_A];
        p[PD_RIGHT] = 1'b0;
        p[PD_LEFT]  = 1'b0;
        p[PD_DOWN]  = 1'b0;
        p[PD_UP]    = 1'b0;
      end
      ROW_ALLHI: begin
        p[PD_TR]    = ~joy[JB_START];
        p[PD_TL]    = ~joy[JB_A];
        p[PD_RIGHT] = 1'b1;
        p[PD_LEFT]  = 1'b1;
        p[PD_DOWN]  = 1'b1;
        p[PD_UP]    = 1'b1;
      end
      default: p = 6'h3F;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/md_pad_responder_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by a rise/fall
// detector on the synchronized level; reusable for any user-port input.
module sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= RESET_VAL;
      level <= RESET_VAL;
      prev  <= RESET_VAL;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = ~prev & level;
  assign fall = prev & ~level;

endmodule

// File: rtl/md_pad_responder.sv
// Mega Drive 3/6-button pad model: follows the host TH select line and drives
// the active-low DB9 data lines from a snapshot of the joystick word.
module md_pad_responder
  import md_pad_pkg::*;
#(
  parameter bit SIX_BUTTON     = 1'b1,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        th_in,
  input  logic [11:0] joystick,
  output logic [5:0]  pad_out,
  output logic [2:0]  phase,
  output logic        frame_done
);

  localparam int             TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  T_SAT  = TW'(TIMEOUT_CYCLES);

  logic          th_sync;
  logic          th_rise;
  logic          th_fall;

  logic [2:0]    phase_q;
  logic [2:0]    k_base;
  logic [2:0]    k_next;
  logic [11:0]   snap;
  logic [11:0]   snap_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          timeout_hit;
  pad_row_e      row;
  logic [5:0]    pad_next;
  logic          frame_done_next;

  sync_edge #(
    .RESET_VAL(1'b1)
  ) u_th_sync (
    .clk  (clk),
    .reset(reset),
    .pin  (th_in),
    .level(th_sync),
    .rise (th_rise),
    .fall (th_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= 3'd0;
      snap       <= 12'h000;
      timer      <= '0;
      pad_out    <= 6'h3F;
      frame_done <= 1'b0;
    end else begin
      phase_q    <= k_next;
      snap       <= snap_next;
      timer      <= timer_next;
      pad_out    <= pad_next;
      frame_done <= frame_done_next;
    end
  end

  // A timeout landing with a fall is applied first, so that fall opens a new frame.
  always_comb begin
    timeout_hit = (timer == T_LAST);
    k_base      = timeout_hit ? 3'd0 : phase_q;
    k_next      = k_base;
    snap_next   = snap;
    timer_next  = timer;
    row         = ROW_DPAD;

    if (!SIX_BUTTON) begin
      k_next = 3'd0;
    end else if (th_fall) begin
      k_next = (k_base >= PHASE_MAX) ? PHASE_MAX : k_base + 3'd1;
    end

    if ((k_base == 3'd0) && (th_fall || th_sync)) begin
      snap_next = joystick;
    end

    if (th_rise || th_fall) begin
      timer_next = '0;
    end else if (timer != T_SAT) begin
      timer_next = timer + TW'(1);
    end

    if (th_sync) begin
      row = (SIX_BUTTON && (k_next == PHASE_ID)) ? ROW_EXTRA : ROW_DPAD;
    end else if (!SIX_BUTTON) begin
      row = ROW_START;
    end else if (k_next == PHASE_ID) begin
      row = ROW_ID;
    end else if (k_next == PHASE_MAX) begin
      row = ROW_ALLHI;
    end else begin
      row = ROW_START;
    end

    pad_next        = pad_encode(snap_next, row);
    frame_done_next = (phase_q == PHASE_ID) && (k_next == PHASE_MAX);
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_md_pad_responder.sv
// Directed bench for md_pad_responder: six-button, fast-timeout and
// three-button instances share stimulus; each test resets before use.
module tb_md_pad_responder;

  localparam int TO_A = 60000;
  localparam int TO_B = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        th;
  logic [11:0] joy;

  logic [5:0]  pad_a, pad_b, pad_c;
  logic [2:0]  phase_a, phase_b, phase_c;
  logic        fd_a, fd_b, fd_c;

  int total = 0;
  int bad   = 0;
  int fd_cnt_a = 0;
  int fd_cnt_b = 0;
  int fd_cnt_c = 0;
  int fd_base;

  logic [5:0] frame_lo [4] = '{6'h33, 6'h33, 6'h30, 6'h3F};
  logic [5:0] frame_hi [4] = '{6'h1F, 6'h1F, 6'h13, 6'h1F};

  md_pad_responder #(.SIX_BUTTON(1'b1), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk(clk), .reset(reset), .th_in(th), .joystick(joy),
    .pad_out(pad_a), .phase(phase_a), .frame_done(fd_a)
  );

  md_pad_responder #(.SIX_BUTTON(1'b1), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .reset(reset), .th_in(th), .joystick(joy),
    .pad_out(pad_b), .phase(phase_b), .frame_done(fd_b)
  );

  md_pad_responder #(.SIX_BUTTON(1'b0), .TIMEOUT_CYCLES(TO_A)) dut_c (
    .clk(clk), .reset(reset), .th_in(th), .joystick(joy),
    .pad_out(pad_c), .phase(phase_c), .frame_done(fd_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fd_a) fd_cnt_a++;
    if (fd_b) fd_cnt_b++;
    if (fd_c) fd_cnt_c++;
  end

  task automatic applyStimulus(input logic r, input logic t, input logic [11:0] j, input int cycles);
    reset = r;
    th    = t;
    joy   = j;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  initial begin
    reset = 1'b1;
    th    = 1'b0;
    joy   = 12'hFFF;

    // reset with TH low; the synchronizer's high reset value yields one fall
    applyStimulus(1'b1, 1'b0, 12'hFFF, 4);
    checkOutput("rst_pad", 32'(pad_a), 32'h3F);
    checkOutput("rst_phase", 32'(phase_a), 32'd0);
    checkOutput("rst_fd", 32'(fd_a), 32'd0);
    checkOutput("rst_pad_c", 32'(pad_c), 32'h3F);
    applyStimulus(1'b0, 1'b0, 12'hFFF, 2);
    checkOutput("rel_phase_early", 32'(phase_a), 32'd0);
    applyStimulus(1'b0, 1'b0, 12'hFFF, 1);
    checkOutput("rel_phase", 32'(phase_a), 32'd1);
    checkOutput("rel_pad", 32'(pad_a), 32'h00);

    // three-button read with U and A pressed, including 3-cycle latency
    applyStimulus(1'b1, 1'b1, 12'h048, 2);
    applyStimulus(1'b0, 1'b1, 12'h048, 1);
    checkOutput("3b_idle", 32'(pad_a), 32'h3E);
    applyStimulus(1'b0, 1'b1, 12'h010, 1);
    checkOutput("3b_live", 32'(pad_a), 32'h2F);
    applyStimulus(1'b0, 1'b1, 12'h048, 1);
    applyStimulus(1'b0, 1'b0, 12'h048, 2);
    checkOutput("3b_lo_lat2", 32'(pad_a), 32'h3E);
    applyStimulus(1'b0, 1'b0, 12'h048, 1);
    checkOutput("3b_lo", 32'(pad_a), 32'h22);
    applyStimulus(1'b0, 1'b1, 12'h048, 2);
    checkOutput("3b_hi_lat2", 32'(pad_a), 32'h22);
    applyStimulus(1'b0, 1'b1, 12'h048, 1);
    checkOutput("3b_hi", 32'(pad_a), 32'h3E);
    applyStimulus(1'b0, 1'b1, 12'h000, 3);
    checkOutput("3b_snap_hold", 32'(pad_a), 32'h3E);
    checkOutput("3b_phase", 32'(phase_a), 32'd1);

    // full six-button frame with C, Mode and X pressed
    fd_base = fd_cnt_a;
    applyStimulus(1'b1, 1'b1, 12'h320, 2);
    applyStimulus(1'b0, 1'b1, 12'h320, 5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 12'h320, 10);
      checkOutput($sformatf("frame_lo%0d_pad", i), 32'(pad_a), 32'(frame_lo[i]));
      checkOutput($sformatf("frame_lo%0d_phase", i), 32'(phase_a), 32'(i + 1));
      applyStimulus(1'b0, 1'b1, 12'h320, 10);
      checkOutput($sformatf("frame_hi%0d_pad", i), 32'(pad_a), 32'(frame_hi[i]));
    end
    checkOutput("frame_done_cnt", 32'(fd_cnt_a - fd_base), 32'd1);
    applyStimulus(1'b0, 1'b0, 12'h320, 10);
    checkOutput("extra_lo_pad", 32'(pad_a), 32'h3F);
    checkOutput("extra_lo_phase", 32'(phase_a), 32'd4);
    applyStimulus(1'b0, 1'b1, 12'h320, 10);
    checkOutput("extra_hi_pad", 32'(pad_a), 32'h1F);
    checkOutput("extra_fd_cnt", 32'(fd_cnt_a - fd_base), 32'd1);
    applyStimulus(1'b1, 1'b1, 12'h320, 1);
    checkOutput("midreset_pad", 32'(pad_a), 32'h3F);
    checkOutput("midreset_phase", 32'(phase_a), 32'd0);

    // timeout after two falls, then a fresh frame reaches the ID phase
    applyStimulus(1'b1, 1'b1, 12'h320, 2);
    applyStimulus(1'b0, 1'b1, 12'h320, 5);
    applyStimulus(1'b0, 1'b0, 12'h320, 10);
    applyStimulus(1'b0, 1'b1, 12'h320, 10);
    applyStimulus(1'b0, 1'b0, 12'h320, 10);
    applyStimulus(1'b0, 1'b1, 12'h320, TO_A + 2);
    checkOutput("to_before", 32'(phase_a), 32'd2);
    applyStimulus(1'b0, 1'b1, 12'h320, 1);
    checkOutput("to_after", 32'(phase_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 12'h320, 10);
      checkOutput($sformatf("to_lo%0d_phase", i), 32'(phase_a), 32'(i + 1));
      if (i == 2) checkOutput("to_id_pad", 32'(pad_a), 32'h30);
      applyStimulus(1'b0, 1'b1, 12'h320, 10);
    end

    // fall coinciding with timeout at k=2 on the fast-timeout instance
    applyStimulus(1'b1, 1'b1, 12'h000, 2);
    applyStimulus(1'b0, 1'b1, 12'h000, 5);
    applyStimulus(1'b0, 1'b0, 12'h000, 10);
    applyStimulus(1'b0, 1'b1, 12'h000, 10);
    applyStimulus(1'b0, 1'b0, 12'h000, 10);
    applyStimulus(1'b0, 1'b1, 12'h000, TO_B);
    checkOutput("sim_pre", 32'(phase_b), 32'd2);
    applyStimulus(1'b0, 1'b0, 12'h048, 2);
    checkOutput("sim_mid", 32'(phase_b), 32'd2);
    applyStimulus(1'b0, 1'b0, 12'h048, 1);
    checkOutput("sim_phase", 32'(phase_b), 32'd1);
    checkOutput("sim_snap", 32'(pad_b), 32'h22);
    applyStimulus(1'b0, 1'b1, 12'h048, 10);
    checkOutput("sim_hi", 32'(pad_b), 32'h3E);
    applyStimulus(1'b0, 1'b0, 12'h048, 10);
    checkOutput("sim_next_phase", 32'(phase_b), 32'd2);
    checkOutput("sim_noid", 32'(pad_b), 32'h22);

    // plain three-button instance with Z pressed
    fd_base = fd_cnt_c;
    applyStimulus(1'b1, 1'b1, 12'h800, 2);
    applyStimulus(1'b0, 1'b1, 12'h800, 5);
    checkOutput("six0_idle", 32'(pad_c), 32'h3F);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 12'h800, 10);
      checkOutput($sformatf("six0_lo%0d_pad", i), 32'(pad_c), 32'h33);
      checkOutput($sformatf("six0_lo%0d_phase", i), 32'(phase_c), 32'd0);
      applyStimulus(1'b0, 1'b1, 12'h800, 10);
      checkOutput($sformatf("six0_hi%0d_pad", i), 32'(pad_c), 32'h3F);
    end
    checkOutput("six0_fd_cnt", 32'(fd_cnt_c - fd_base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
